// File: rtl/jiacheng_seq_pkg.sv
// rtl/jiacheng_seq_pkg.sv - op and state encodings shared by the jiacheng_seq slice
package jiacheng_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_MAC = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MULT = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/jiacheng_seq_if.sv
// rtl/jiacheng_seq_if.sv - start/busy/done request and result bundle for jiacheng_seq
interface jiacheng_seq_if #(
   parameter int W = 6
);
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [1:0]     sl;
   logic           busy;
   logic           done;
   logic [2*W-1:0] c;
   logic           ovf;

   modport master (output start, a, b, sl, input busy, done, c, ovf);
   modport slave  (input start, a, b, sl, output busy, done, c, ovf);
endinterface

// File: rtl/jiacheng_seq_shift_mul.sv
// rtl/jiacheng_seq_shift_mul.sv - W-iteration shift-add multiplier datapath with its counter
module jiacheng_shift_mul #(
   parameter int W  = 6,
   parameter int CW = $clog2(W) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           step_en,
   output logic [2*W-1:0] product,
   output logic           last
);
   logic [2*W-1:0] r_mcand;
   logic [2*W-1:0] r_prod;
   logic [W-1:0]   r_mplier;
   logic [CW-1:0]  r_cnt;

   // product already includes the current step, so the final value is ready on the last MULT edge
   assign product = r_prod + (r_mplier[0] ? r_mcand : '0);
   assign last    = (r_cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_prod   <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (load) begin
         r_mcand  <= {{W{1'b0}}, a};
         r_prod   <= '0;
         r_mplier <= b;
         r_cnt    <= CW'(W);
      end else if (step_en) begin
         r_prod   <= product;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt - 1'b1;
      end
   end
endmodule

// File: rtl/jiacheng_seq.sv
// rtl/jiacheng_seq.sv - sequential add/sub/multiply unit behind a start/busy/done handshake
// JIACHENG_SEQ_MAC_EN turns sl=11 into multiply-accumulate; otherwise sl=11 is a plain multiply.
module jiacheng_seq
   import jiacheng_pkg::*;
#(
   parameter  int W  = 6,
   localparam int CW = $clog2(W) + 1
) (
   input  logic          clk,
   input  logic          rst,
   jiacheng_seq_if.slave bus
);
   state_e         r_state;
   state_e         w_next;
   op_e            w_sl;
   logic           w_accept;
   logic           w_load;
   logic           w_step;
   logic           w_last;
   logic [2*W-1:0] w_product;
   logic [W:0]     w_sum;
   logic [W:0]     w_diff;
   logic [2*W-1:0] r_c;
   logic           r_ovf;
   logic           r_done;
   logic           r_busy;
`ifdef JIACHENG_SEQ_MAC_EN
   op_e            r_op;
   logic [2*W-1:0] r_acc;
   logic [2*W:0]   w_mac;

   assign w_mac = {1'b0, r_acc} + {1'b0, w_product};
`endif

   assign w_sl   = op_e'(bus.sl);
   assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
   assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

   jiacheng_shift_mul #(.W(W), .CW(CW)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .load    (w_load),
      .a       (bus.a),
      .b       (bus.b),
      .step_en (w_step),
      .product (w_product),
      .last    (w_last)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_load   = 1'b0;
      w_step   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_accept = 1'b1;
               if (w_sl == OP_MUL || w_sl == OP_MAC) begin
                  w_load = 1'b1;
                  w_next = ST_MULT;
               end else begin
                  w_next = ST_DONE;
               end
            end
         end
         ST_MULT: begin
            w_step = 1'b1;
            if (w_last) w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // result and flag are written on the edge entering DONE so they are valid with done
   always_ff @(posedge clk) begin
      if (rst) begin
         r_c    <= '0;
         r_ovf  <= 1'b0;
         r_done <= 1'b0;
         r_busy <= 1'b0;
`ifdef JIACHENG_SEQ_MAC_EN
         r_op   <= OP_ADD;
`endif
      end else begin
         r_done <= (w_next == ST_DONE);
         r_busy <= (w_next != ST_IDLE);
         if (w_accept) begin
`ifdef JIACHENG_SEQ_MAC_EN
            r_op <= w_sl;
`endif
            if (w_sl == OP_ADD) begin
               r_c   <= {{W{1'b0}}, w_sum[W-1:0]};
               r_ovf <= w_sum[W];
            end else if (w_sl == OP_SUB) begin
               r_c   <= {{W{1'b0}}, w_diff[W-1:0]};
               r_ovf <= w_diff[W];
            end
         end
         if (w_step && w_last) begin
`ifdef JIACHENG_SEQ_MAC_EN
            if (r_op == OP_MAC) begin
               r_c   <= w_mac[2*W-1:0];
               r_ovf <= w_mac[2*W];
            end else begin
               r_c   <= w_product;
               r_ovf <= 1'b0;
            end
`else
            r_c   <= w_product;
            r_ovf <= 1'b0;
`endif
         end
      end
   end

`ifdef JIACHENG_SEQ_MAC_EN
   always_ff @(posedge clk) begin
      if (rst)                                      r_acc <= '0;
      else if (w_step && w_last && r_op == OP_MAC) r_acc <= w_mac[2*W-1:0];
   end
`endif

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.c    = r_c;
   assign bus.ovf  = r_ovf;
endmodule
